ysyx_24110006_ifu: RTL and testbench



---
 rtl/ysyx_24110006_pkg.sv | 28 ++
 rtl/ysyx_24110006_immgen.sv | 28 ++
 rtl/ysyx_24110006_ifu.sv | 113 +++++++++++
 tb/tb_ysyx_24110006_ifu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the ysyx_24110006 fetch path: opcodes, bus response codes
// and the fetch FSM state encoding.
package ysyx_24110006_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned RESP_W = 2;

  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_SEND = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24110006_immgen.sv
// Combinational RV32 immediate generator: sign-extended immediate selected by opcode.
module ysyx_24110006_immgen
  import ysyx_24110006_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      // Unknown opcodes pass funct7 through so the decoder can still inspect it.
      default:
        imm = {25'b0, inst[31:25]};
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, registered inst/imm/pc
// handed to the IDU with a single-cycle valid pulse, then waits for the next PC.
module ysyx_24110006_ifu
  import ysyx_24110006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic [XLEN-1:0]   o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [XLEN-1:0]   i_rdata,
  input  logic [RESP_W-1:0] i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [XLEN-1:0]   o_inst,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_fault,
  output logic              o_valid,
  input  logic              i_pc_valid,
  input  logic [XLEN-1:0]   i_dnpc
);

  ifu_state_e      state, next_state;
  logic            boot;
  logic            pend;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] imm_c;

  ysyx_24110006_immgen u_immgen (
    .inst (i_rdata),
    .imm  (imm_c)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (boot || pend || i_pc_valid) next_state = ST_REQ;
      ST_REQ:  if (i_arready)                  next_state = ST_RESP;
      ST_RESP: if (i_rvalid)                   next_state = ST_SEND;
      ST_SEND:                                 next_state = ST_IDLE;
      default:                                 next_state = ST_IDLE;
    endcase
  end

  // Bus handshake signals decode straight from state; address is the held pc.
  always_comb begin
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_araddr  = pc;
    case (state)
      ST_REQ:  o_arvalid = 1'b1;
      ST_RESP: o_rready  = 1'b1;
      default: ;
    endcase
  end

  // PC selection: boot fetch first, then a parked handoff, then a live one.
  // A handoff arriving mid-fetch is parked (last one wins) rather than aborting.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      boot    <= 1'b1;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (state == ST_IDLE) begin
      if (boot) begin
        boot <= 1'b0;
      end else if (pend) begin
        pc   <= pend_pc;
        pend <= 1'b0;
      end else if (i_pc_valid) begin
        pc <= i_dnpc;
      end
    end else if (i_pc_valid) begin
      pend    <= 1'b1;
      pend_pc <= i_dnpc;
    end
  end

  // Response capture; a faulting fetch presents zeroed inst/imm.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_inst  <= '0;
      o_imm   <= '0;
      o_pc    <= '0;
      o_fault <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= (next_state == ST_SEND);
      if (state == ST_RESP && i_rvalid) begin
        o_pc    <= pc;
        o_fault <= (i_rresp != RESP_OKAY);
        if (i_rresp != RESP_OKAY) begin
          o_inst <= '0;
          o_imm  <= '0;
        end else begin
          o_inst <= i_rdata;
          o_imm  <= imm_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Directed bench for ysyx_24110006_ifu: boot fetch, arready stall, immediate sweep,
// fault response, mid-fetch PC handoff and asynchronous reset during a fetch.
module tb_ysyx_24110006_ifu;

  logic        i_clock;
  logic        i_reset_n;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] o_inst;
  logic [31:0] o_imm;
  logic [31:0] o_pc;
  logic        o_fault;
  logic        o_valid;
  logic        i_pc_valid;
  logic [31:0] i_dnpc;

  int checks = 0;
  int errors = 0;

  ysyx_24110006_ifu dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .o_araddr   (o_araddr),
    .o_arvalid  (o_arvalid),
    .i_arready  (i_arready),
    .i_rdata    (i_rdata),
    .i_rresp    (i_rresp),
    .i_rvalid   (i_rvalid),
    .o_rready   (o_rready),
    .o_inst     (o_inst),
    .o_imm      (o_imm),
    .o_pc       (o_pc),
    .o_fault    (o_fault),
    .o_valid    (o_valid),
    .i_pc_valid (i_pc_valid),
    .i_dnpc     (i_dnpc)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  // One-cycle next-PC strobe, driven from a falling edge.
  task automatic handoff(input logic [31:0] dnpc);
    i_dnpc     = dnpc;
    i_pc_valid = 1'b1;
    step();
    i_pc_valid = 1'b0;
  endtask

  // Full fetch from IDLE; captures the pulse payload and returns to IDLE.
  task automatic do_fetch(input logic [31:0] dnpc, input logic [31:0] data,
                          input logic [1:0] resp, output logic seen,
                          output logic [31:0] inst, output logic [31:0] imm,
                          output logic [31:0] pc, output logic fault);
    seen = 1'b0; inst = '0; imm = '0; pc = '0; fault = 1'b0;
    i_rdata = data;
    i_rresp = resp;
    handoff(dnpc);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (o_valid) begin
        seen = 1'b1; inst = o_inst; imm = o_imm; pc = o_pc; fault = o_fault;
      end else begin
        step();
      end
    end
    step();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (3) step();
    checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", o_arvalid); end
    checks++; if (o_rready !== 1'b0)  begin errors++; $display("FAIL reset_rready got %b want 0", o_rready); end
    checks++; if (o_inst !== 32'h0)   begin errors++; $display("FAIL reset_inst got %h want 0", o_inst); end
    checks++; if (o_imm !== 32'h0)    begin errors++; $display("FAIL reset_imm got %h want 0", o_imm); end
    checks++; if (o_fault !== 1'b0)   begin errors++; $display("FAIL reset_fault got %b want 0", o_fault); end
  endtask

  // Releases reset at a falling edge and follows the automatic boot fetch.
  task automatic run_boot(input string tag);
    int pulses = 0;
    int first  = 0;
    logic [31:0] inst = '0, imm = '0, pc = '0;
    logic        fault = 1'b1;
    i_rdata   = 32'h00500093;
    i_rresp   = 2'b00;
    i_arready = 1'b1;
    i_rvalid  = 1'b1;
    i_reset_n = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      if (cyc == 1) begin
        checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h80000000) begin
          errors++; $display("FAIL %s_req got arvalid=%b araddr=%h want 1 80000000", tag, o_arvalid, o_araddr);
        end
      end
      if (o_valid) begin
        pulses++;
        if (pulses == 1) begin
          first = cyc; inst = o_inst; imm = o_imm; pc = o_pc; fault = o_fault;
        end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", tag, pulses); end
    checks++; if (first != 3)  begin errors++; $display("FAIL %s_latency got %0d want 3", tag, first); end
    checks++; if (inst !== 32'h00500093) begin errors++; $display("FAIL %s_inst got %h want 00500093", tag, inst); end
    checks++; if (imm !== 32'h5)         begin errors++; $display("FAIL %s_imm got %h want 00000005", tag, imm); end
    checks++; if (pc !== 32'h80000000)   begin errors++; $display("FAIL %s_pc got %h want 80000000", tag, pc); end
    checks++; if (fault !== 1'b0)        begin errors++; $display("FAIL %s_fault got %b want 0", tag, fault); end
  endtask

  task automatic test_boot();
    run_boot("boot");
  endtask

  task automatic test_arready_stall();
    int   hs = 0;
    logic seen = 1'b0;
    logic [31:0] pc = '0;
    i_arready = 1'b0;
    i_rdata   = 32'h00500093;
    i_rresp   = 2'b00;
    handoff(32'h80000020);
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h80000020) begin
        errors++; $display("FAIL stall_hold%0d got arvalid=%b araddr=%h want 1 80000020", k, o_arvalid, o_araddr);
      end
      if (o_arvalid && i_arready) hs++;
      step();
    end
    i_arready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (o_arvalid && i_arready) hs++;
      if (o_valid) begin seen = 1'b1; pc = o_pc; end
      else step();
    end
    step();
    checks++; if (hs != 1)     begin errors++; $display("FAIL stall_handshakes got %0d want 1", hs); end
    checks++; if (seen !== 1'b1 || pc !== 32'h80000020) begin
      errors++; $display("FAIL stall_resp got seen=%b pc=%h want 1 80000020", seen, pc);
    end
  endtask

  task automatic test_imm_sweep();
    logic [31:0] vec [5] = '{32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h0000006F, 32'h00112623};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C};
    logic        seen, fault;
    logic [31:0] inst, imm, pc, addr;
    for (int i = 0; i < 5; i++) begin
      addr = 32'h80000100 + 32'(4 * i);
      do_fetch(addr, vec[i], 2'b00, seen, inst, imm, pc, fault);
      checks++; if (seen !== 1'b1 || imm !== exp[i]) begin
        errors++; $display("FAIL imm%0d got seen=%b imm=%h want 1 %h", i, seen, imm, exp[i]);
      end
      checks++; if (pc !== addr || inst !== vec[i]) begin
        errors++; $display("FAIL imm%0d_pc got pc=%h inst=%h want %h %h", i, pc, inst, addr, vec[i]);
      end
    end
  endtask

  task automatic test_fault();
    logic        seen, fault;
    logic [31:0] inst, imm, pc;
    do_fetch(32'h80000200, 32'hFFF00093, 2'b10, seen, inst, imm, pc, fault);
    checks++; if (seen !== 1'b1 || fault !== 1'b1) begin
      errors++; $display("FAIL fault_flag got seen=%b fault=%b want 1 1", seen, fault);
    end
    checks++; if (inst !== 32'h0 || imm !== 32'h0) begin
      errors++; $display("FAIL fault_zero got inst=%h imm=%h want 0 0", inst, imm);
    end
    i_rresp = 2'b00;
  endtask

  task automatic test_pending_pc();
    logic seen = 1'b0;
    logic [31:0] pc = '0;
    logic stray = 1'b0;
    i_rdata  = 32'h00500093;
    i_rvalid = 1'b0;
    handoff(32'h80000040);
    step();
    checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL pend_inresp got rready=%b want 1", o_rready); end
    i_dnpc = 32'h80000010; i_pc_valid = 1'b1;
    step();
    i_pc_valid = 1'b0;
    i_rvalid   = 1'b1;
    step();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h80000040) begin
      errors++; $display("FAIL pend_first got valid=%b pc=%h want 1 80000040", o_valid, o_pc);
    end
    step();
    step();
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h80000010) begin
      errors++; $display("FAIL pend_refetch got arvalid=%b araddr=%h want 1 80000010", o_arvalid, o_araddr);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      if (o_valid) begin seen = 1'b1; pc = o_pc; end
      else step();
    end
    checks++; if (seen !== 1'b1 || pc !== 32'h80000010) begin
      errors++; $display("FAIL pend_second got seen=%b pc=%h want 1 80000010", seen, pc);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (o_arvalid || o_valid) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL pend_idle got extra activity=%b want 0", stray); end
  endtask

  task automatic test_reset_mid();
    i_rdata  = 32'hFFF00093;
    i_rvalid = 1'b0;
    handoff(32'h80000300);
    step();
    checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL rstmid_inresp got rready=%b want 1", o_rready); end
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_rready !== 1'b0 || o_arvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got valid=%b rready=%b arvalid=%b want 0 0 0", o_valid, o_rready, o_arvalid);
    end
    checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL rstmid_inst got %h want 0", o_inst); end
    @(negedge i_clock);
    step();
    run_boot("rstmid_boot");
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_arready  = 1'b1;
    i_rvalid   = 1'b1;
    i_rresp    = 2'b00;
    i_rdata    = 32'h0;
    i_pc_valid = 1'b0;
    i_dnpc     = 32'h0;
    @(negedge i_clock);
    test_reset();
    test_boot();
    test_arready_stall();
    test_imm_sweep();
    test_fault();
    test_pending_pc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
